// File: rtl/photon_counter_if.sv
// Configuration bus for photon_counter: timebase selection, sequencer timing and count window length.
interface photon_counter_if;
    logic        sync_src;
    logic [7:0]  sync_div;
    logic [31:0] clk_divide;
    logic [16:0] max_count_f;
    logic [31:0] pulsePeriod_div;
    logic [31:0] pw_div_out0;
    logic [31:0] pw_div_out1;
    logic [31:0] delay_div_out0;
    logic [31:0] delay_div_out1;
    logic [31:0] pw_div_in0;
    logic [31:0] pw_div_in1;
    logic [31:0] delay_div_in0;
    logic [31:0] delay_div_in1;
    logic [31:0] slow_pulsePeriod_div;
    logic [31:0] slow_pw_div_out0;
    logic [31:0] slow_pw_div_out1;
    logic [31:0] slow_delay_div_out0;
    logic [31:0] slow_delay_div_out1;
    logic [31:0] slow_pw_div_in0;
    logic [31:0] slow_pw_div_in1;
    logic [31:0] slow_delay_div_in0;
    logic [31:0] slow_delay_div_in1;

    modport master (
        output sync_src, sync_div, clk_divide, max_count_f, pulsePeriod_div,
               pw_div_out0, pw_div_out1, delay_div_out0, delay_div_out1,
               pw_div_in0, pw_div_in1, delay_div_in0, delay_div_in1,
               slow_pulsePeriod_div,
               slow_pw_div_out0, slow_pw_div_out1, slow_delay_div_out0, slow_delay_div_out1,
               slow_pw_div_in0, slow_pw_div_in1, slow_delay_div_in0, slow_delay_div_in1
    );

    modport slave (
        input  sync_src, sync_div, clk_divide, max_count_f, pulsePeriod_div,
               pw_div_out0, pw_div_out1, delay_div_out0, delay_div_out1,
               pw_div_in0, pw_div_in1, delay_div_in0, delay_div_in1,
               slow_pulsePeriod_div,
               slow_pw_div_out0, slow_pw_div_out1, slow_delay_div_out0, slow_delay_div_out1,
               slow_pw_div_in0, slow_pw_div_in1, slow_delay_div_in0, slow_delay_div_in1
    );
endinterface

// File: rtl/photon_counter.sv
// Gated two-channel photon counter driven by a fast/slow pulse sequencer on a divided timebase.
// Define PHC_SATURATE_EN to make the photon accumulators saturate at all-ones instead of wrapping.
module photon_counter #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             pmt_in1,
    input  logic             pmt_in2,
    input  logic             sync_in,
    photon_counter_if.slave  cfg,
    output logic [1:0]       pulse_out,
    output logic [1:0]       slow_pulse_out,
    output logic             phcountbool,
    output logic             pmt_out,
    output logic             reset_out,
    output logic [CNT_W-1:0] count0,
    output logic [CNT_W-1:0] count1,
    output logic             count_valid,
    output logic [7:0]       led
);
    localparam logic [CNT_W-1:0] ACC_ONE = CNT_W'(1);

    logic [2:0]                  w_async;
    logic [2:0][SYNC_STAGES-1:0] r_sync;
    logic [2:0]                  w_syncLvl;
    logic [2:0]                  r_syncPrev;
    logic [2:0]                  w_rise;
    logic                        r_pmtOut;

    logic        r_syncSrcQ;
    logic        w_srcChange;
    logic [31:0] r_clkDivCnt;
    logic [7:0]  r_syncDivCnt;
    logic        w_tick;

    logic [31:0] r_fph;
    logic [31:0] r_sph;
    logic [31:0] w_fphLast;
    logic [31:0] w_sphLast;
    logic        w_fwrap;

    logic [1:0]  r_pulseOut;
    logic [1:0]  r_slowOut;
    logic [1:0]  r_gate;

    logic [16:0]      r_winCnt;
    logic [16:0]      w_maxEff;
    logic             w_winEnd;
    logic [CNT_W-1:0] r_acc0;
    logic [CNT_W-1:0] r_acc1;
    logic [CNT_W-1:0] w_acc0Next;
    logic [CNT_W-1:0] w_acc1Next;
    logic [CNT_W-1:0] r_count0;
    logic [CNT_W-1:0] r_count1;
    logic             r_countValid;

    function automatic logic win(input logic [31:0] ph, input logic [31:0] d, input logic [31:0] w);
        logic [32:0] p;
        logic [32:0] lo;
        logic [32:0] hi;
        p  = {1'b0, ph};
        lo = {1'b0, d};
        hi = lo + {1'b0, w};
        return (lo <= p) && (p < hi);
    endfunction

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic en);
        logic [CNT_W-1:0] nxt;
        nxt = v;
`ifdef PHC_SATURATE_EN
        if (en && (v != '1)) nxt = v + ACC_ONE;
`else
        if (en) nxt = v + ACC_ONE;
`endif
        return nxt;
    endfunction

    assign w_async = {sync_in, pmt_in2, pmt_in1};

    // Bit 0 of each chain takes the raw input; the top bit is the synchronized level.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_sync     <= '0;
            r_syncPrev <= '0;
            r_pmtOut   <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_async[i]};
            end
            r_syncPrev <= w_syncLvl;
            r_pmtOut   <= w_syncLvl[0] | w_syncLvl[1];
        end
    end

    always_comb begin
        w_syncLvl = '0;
        for (int i = 0; i < 3; i++) begin
            w_syncLvl[i] = r_sync[i][SYNC_STAGES-1];
        end
    end

    assign w_rise = w_syncLvl & ~r_syncPrev;

    // A change of timebase source restarts both dividers and suppresses the tick for that cycle.
    assign w_srcChange = (cfg.sync_src != r_syncSrcQ);
    assign w_tick = !w_srcChange &&
                    (cfg.sync_src ? (w_rise[2] && (r_syncDivCnt >= cfg.sync_div))
                                  : (r_clkDivCnt >= cfg.clk_divide));

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_syncSrcQ   <= 1'b0;
            r_clkDivCnt  <= '0;
            r_syncDivCnt <= '0;
        end else begin
            r_syncSrcQ <= cfg.sync_src;
            if (w_srcChange) begin
                r_clkDivCnt  <= '0;
                r_syncDivCnt <= '0;
            end else if (!cfg.sync_src) begin
                if (r_clkDivCnt >= cfg.clk_divide) r_clkDivCnt <= '0;
                else                               r_clkDivCnt <= r_clkDivCnt + 32'd1;
            end else if (w_rise[2]) begin
                if (r_syncDivCnt >= cfg.sync_div) r_syncDivCnt <= '0;
                else                              r_syncDivCnt <= r_syncDivCnt + 8'd1;
            end
        end
    end

    assign w_fphLast = (cfg.pulsePeriod_div == 32'd0)      ? 32'd0 : cfg.pulsePeriod_div - 32'd1;
    assign w_sphLast = (cfg.slow_pulsePeriod_div == 32'd0) ? 32'd0 : cfg.slow_pulsePeriod_div - 32'd1;
    assign w_fwrap   = w_tick && (r_fph >= w_fphLast);

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_fph <= '0;
            r_sph <= '0;
        end else begin
            if (w_tick) begin
                r_fph <= w_fwrap ? 32'd0 : r_fph + 32'd1;
            end
            if (w_fwrap) begin
                r_sph <= (r_sph >= w_sphLast) ? 32'd0 : r_sph + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_pulseOut <= '0;
            r_slowOut  <= '0;
            r_gate     <= '0;
        end else begin
            r_pulseOut[0] <= win(r_fph, cfg.delay_div_out0, cfg.pw_div_out0);
            r_pulseOut[1] <= win(r_fph, cfg.delay_div_out1, cfg.pw_div_out1);
            r_slowOut[0]  <= win(r_sph, cfg.slow_delay_div_out0, cfg.slow_pw_div_out0);
            r_slowOut[1]  <= win(r_sph, cfg.slow_delay_div_out1, cfg.slow_pw_div_out1);
            r_gate[0]     <= win(r_fph, cfg.delay_div_in0, cfg.pw_div_in0) &&
                             win(r_sph, cfg.slow_delay_div_in0, cfg.slow_pw_div_in0);
            r_gate[1]     <= win(r_fph, cfg.delay_div_in1, cfg.pw_div_in1) &&
                             win(r_sph, cfg.slow_delay_div_in1, cfg.slow_pw_div_in1);
        end
    end

    assign w_maxEff   = (cfg.max_count_f == 17'd0) ? 17'd1 : cfg.max_count_f;
    assign w_winEnd   = w_fwrap && ((r_winCnt + 17'd1) >= w_maxEff);
    assign w_acc0Next = bump(r_acc0, w_rise[0] & r_gate[0]);
    assign w_acc1Next = bump(r_acc1, w_rise[1] & r_gate[1]);

    // The latched count includes an edge arriving on the very cycle the window closes.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_winCnt     <= '0;
            r_acc0       <= '0;
            r_acc1       <= '0;
            r_count0     <= '0;
            r_count1     <= '0;
            r_countValid <= 1'b0;
        end else begin
            r_countValid <= w_winEnd;
            if (w_winEnd) begin
                r_winCnt <= '0;
                r_count0 <= w_acc0Next;
                r_count1 <= w_acc1Next;
                r_acc0   <= '0;
                r_acc1   <= '0;
            end else begin
                if (w_fwrap) r_winCnt <= r_winCnt + 17'd1;
                r_acc0 <= w_acc0Next;
                r_acc1 <= w_acc1Next;
            end
        end
    end

    assign pulse_out      = r_pulseOut;
    assign slow_pulse_out = r_slowOut;
    assign phcountbool    = r_gate[0] | r_gate[1];
    assign pmt_out        = r_pmtOut;
    assign reset_out      = r_countValid;
    assign count_valid    = r_countValid;
    assign count0         = r_count0;
    assign count1         = r_count1;
    assign led            = r_count0[7:0];
endmodule

// File: tb/tb_photon_counter.sv
// Directed self-checking bench for photon_counter: sequencer timing, gated counting, external sync and reset.
module tb_photon_counter;
    logic        clk_in  = 1'b0;
    logic        reset_n = 1'b1;
    logic        pmt_in1 = 1'b0;
    logic        pmt_in2 = 1'b0;
    logic        sync_in = 1'b0;
    logic [1:0]  pulse_out;
    logic [1:0]  slow_pulse_out;
    logic        phcountbool;
    logic        pmt_out;
    logic        reset_out;
    logic [31:0] count0;
    logic [31:0] count1;
    logic        count_valid;
    logic [7:0]  led;

    int total = 0;
    int bad   = 0;

    photon_counter_if cfgIf ();

    photon_counter #(.CNT_W(32), .SYNC_STAGES(2)) dut (
        .clk_in         (clk_in),
        .reset_n        (reset_n),
        .pmt_in1        (pmt_in1),
        .pmt_in2        (pmt_in2),
        .sync_in        (sync_in),
        .cfg            (cfgIf),
        .pulse_out      (pulse_out),
        .slow_pulse_out (slow_pulse_out),
        .phcountbool    (phcountbool),
        .pmt_out        (pmt_out),
        .reset_out      (reset_out),
        .count0         (count0),
        .count1         (count1),
        .count_valid    (count_valid),
        .led            (led)
    );

    always #5 clk_in = ~clk_in;

    task automatic setDefaults();
        cfgIf.sync_src             = 1'b0;
        cfgIf.sync_div             = 8'd0;
        cfgIf.clk_divide           = 32'd0;
        cfgIf.max_count_f          = 17'd1;
        cfgIf.pulsePeriod_div      = 32'd1;
        cfgIf.pw_div_out0          = 32'd0;
        cfgIf.pw_div_out1          = 32'd0;
        cfgIf.delay_div_out0       = 32'd0;
        cfgIf.delay_div_out1       = 32'd0;
        cfgIf.pw_div_in0           = 32'd0;
        cfgIf.pw_div_in1           = 32'd0;
        cfgIf.delay_div_in0        = 32'd0;
        cfgIf.delay_div_in1        = 32'd0;
        cfgIf.slow_pulsePeriod_div = 32'd1;
        cfgIf.slow_pw_div_out0     = 32'd0;
        cfgIf.slow_pw_div_out1     = 32'd0;
        cfgIf.slow_delay_div_out0  = 32'd0;
        cfgIf.slow_delay_div_out1  = 32'd0;
        cfgIf.slow_pw_div_in0      = 32'd0;
        cfgIf.slow_pw_div_in1      = 32'd0;
        cfgIf.slow_delay_div_in0   = 32'd0;
        cfgIf.slow_delay_div_in1   = 32'd0;
    endtask

    // Leaves the bench just after a falling edge with reset released; the next rising edge is edge 1.
    task automatic startRun();
        reset_n = 1'b0;
        pmt_in1 = 1'b0;
        pmt_in2 = 1'b0;
        sync_in = 1'b0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        reset_n = 1'b1;
    endtask

    task automatic setFastPattern();
        cfgIf.clk_divide      = 32'd3;
        cfgIf.pulsePeriod_div = 32'd8;
        cfgIf.pw_div_out0     = 32'd2;
        cfgIf.delay_div_out0  = 32'd0;
        cfgIf.pw_div_out1     = 32'd2;
        cfgIf.delay_div_out1  = 32'd4;
    endtask

    task automatic test_reset();
        setDefaults();
        setFastPattern();
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        total++;
        if (pulse_out !== 2'b00) begin
            bad++; $display("[TB] FAIL reset_pulse_out: got %b expected 00", pulse_out);
        end
        total++;
        if (slow_pulse_out !== 2'b00) begin
            bad++; $display("[TB] FAIL reset_slow_pulse_out: got %b expected 00", slow_pulse_out);
        end
        total++;
        if ({count0, count1} !== 64'd0) begin
            bad++; $display("[TB] FAIL reset_counts: got %0h/%0h expected 0/0", count0, count1);
        end
        total++;
        if ({count_valid, reset_out, phcountbool, pmt_out} !== 4'b0000) begin
            bad++; $display("[TB] FAIL reset_strobes: got %b expected 0000",
                            {count_valid, reset_out, phcountbool, pmt_out});
        end
        total++;
        if (led !== 8'd0) begin
            bad++; $display("[TB] FAIL reset_led: got %0h expected 0", led);
        end
    endtask

    // Tick every 4 clocks, 8 ticks per fast period: out0 covers clocks 0-7 and out1 clocks 16-23 of 32.
    task automatic test_fast_pulses();
        logic [1:0] expPulse;
        logic       expValid;
        setDefaults();
        setFastPattern();
        startRun();
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk_in);
            #1;
            expPulse[0] = ((k - 1) % 32) < 8;
            expPulse[1] = (((k - 1) % 32) >= 16) && (((k - 1) % 32) < 24);
            expValid    = (k % 32) == 0;
            total++;
            if (pulse_out !== expPulse) begin
                bad++; $display("[TB] FAIL fast_pulse_out k=%0d: got %b expected %b", k, pulse_out, expPulse);
            end
            total++;
            if (count_valid !== expValid) begin
                bad++; $display("[TB] FAIL fast_window_strobe k=%0d: got %b expected %b", k, count_valid, expValid);
            end
        end
    endtask

    // One tick per clock, 8-clock fast period: slow phase s covers clocks 8s..8s+7 of every 64.
    task automatic test_slow_pulses();
        logic [1:0] expSlow;
        int         s;
        setDefaults();
        cfgIf.pulsePeriod_div      = 32'd8;
        cfgIf.slow_pulsePeriod_div = 32'd8;
        cfgIf.slow_pw_div_out0     = 32'd2;
        cfgIf.slow_delay_div_out0  = 32'd0;
        cfgIf.slow_pw_div_out1     = 32'd2;
        cfgIf.slow_delay_div_out1  = 32'd2;
        startRun();
        for (int k = 1; k <= 128; k++) begin
            @(posedge clk_in);
            #1;
            s = ((k - 1) / 8) % 8;
            expSlow[0] = s < 2;
            expSlow[1] = (s >= 2) && (s < 4);
            total++;
            if (slow_pulse_out !== expSlow) begin
                bad++; $display("[TB] FAIL slow_pulse_out k=%0d: got %b expected %b", k, slow_pulse_out, expSlow);
            end
        end
    endtask

    // PMT edges land on even clocks from 4 on; gate covers clocks 2..pw+1 of each 8-clock period, window = 16 clocks.
    task automatic test_counting(input int pw, input int expFirst, input int expNext);
        logic expValid;
        logic expGate;
        logic expPmt;
        setDefaults();
        cfgIf.pulsePeriod_div      = 32'd8;
        cfgIf.max_count_f          = 17'd2;
        cfgIf.delay_div_in0        = 32'd0;
        cfgIf.pw_div_in0           = pw;
        cfgIf.pw_div_in1           = 32'd0;
        cfgIf.slow_pulsePeriod_div = 32'd1;
        cfgIf.slow_pw_div_in0      = 32'd1;
        cfgIf.slow_pw_div_in1      = 32'd1;
        startRun();
        for (int k = 1; k <= 48; k++) begin
            @(posedge clk_in);
            #1;
            expValid = (k % 16) == 0;
            expGate  = ((k - 1) % 8) < pw;
            expPmt   = (k % 2) == 0;
            total++;
            if ({count_valid, reset_out} !== {expValid, expValid}) begin
                bad++; $display("[TB] FAIL count_strobe pw=%0d k=%0d: got %b%b expected %b%b",
                                pw, k, count_valid, reset_out, expValid, expValid);
            end
            total++;
            if (phcountbool !== expGate) begin
                bad++; $display("[TB] FAIL phcountbool pw=%0d k=%0d: got %b expected %b", pw, k, phcountbool, expGate);
            end
            if (k >= 3) begin
                total++;
                if (pmt_out !== expPmt) begin
                    bad++; $display("[TB] FAIL pmt_out k=%0d: got %b expected %b", k, pmt_out, expPmt);
                end
            end
            if (k == 16) begin
                total++;
                if (count0 !== expFirst) begin
                    bad++; $display("[TB] FAIL count0_first pw=%0d: got %0d expected %0d", pw, count0, expFirst);
                end
            end
            if (k == 32 || k == 48) begin
                total++;
                if (count0 !== expNext) begin
                    bad++; $display("[TB] FAIL count0_window pw=%0d k=%0d: got %0d expected %0d", pw, k, count0, expNext);
                end
                total++;
                if (led !== expNext[7:0]) begin
                    bad++; $display("[TB] FAIL led pw=%0d k=%0d: got %0d expected %0d", pw, k, led, expNext[7:0]);
                end
                total++;
                if (count1 !== 32'd0) begin
                    bad++; $display("[TB] FAIL count1_closed_gate k=%0d: got %0d expected 0", k, count1);
                end
            end
            @(negedge clk_in);
            pmt_in1 = ~pmt_in1;
            pmt_in2 = ~pmt_in2;
        end
    endtask

    // 16 sync_in rising edges, every 8 clocks; period 4 ticks and a one-period window -> 4 strobes 32 clocks apart.
    task automatic test_sync_external();
        int strobes;
        int lastStrobe;
        strobes    = 0;
        lastStrobe = 0;
        setDefaults();
        cfgIf.sync_src        = 1'b1;
        cfgIf.sync_div        = 8'd0;
        cfgIf.pulsePeriod_div = 32'd4;
        cfgIf.max_count_f     = 17'd1;
        cfgIf.clk_divide      = 32'd0;
        startRun();
        for (int c = 1; c <= 150; c++) begin
            @(posedge clk_in);
            #1;
            if (count_valid === 1'b1) begin
                strobes++;
                if (lastStrobe > 0) begin
                    total++;
                    if (c - lastStrobe != 32) begin
                        bad++; $display("[TB] FAIL sync_strobe_gap: got %0d expected 32", c - lastStrobe);
                    end
                end
                lastStrobe = c;
            end
            @(negedge clk_in);
            sync_in = (c <= 128) && ((c % 8) >= 4);
        end
        total++;
        if (strobes != 4) begin
            bad++; $display("[TB] FAIL sync_strobe_count: got %0d expected 4", strobes);
        end
    endtask

    // Full gate, one-period window of 32 clocks: 15 even-clock edges (4..32) land in the first window.
    task automatic test_reset_mid();
        logic [1:0] expPulse;
        setDefaults();
        setFastPattern();
        cfgIf.max_count_f          = 17'd1;
        cfgIf.delay_div_in0        = 32'd0;
        cfgIf.pw_div_in0           = 32'd8;
        cfgIf.slow_pulsePeriod_div = 32'd1;
        cfgIf.slow_pw_div_in0      = 32'd1;
        startRun();
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk_in);
            #1;
            if (k == 33) begin
                total++;
                if (count0 !== 32'd15) begin
                    bad++; $display("[TB] FAIL midrun_count0: got %0d expected 15", count0);
                end
            end
            if (k == 34) begin
                total++;
                if (pulse_out !== 2'b01) begin
                    bad++; $display("[TB] FAIL midrun_pulse_out: got %b expected 01", pulse_out);
                end
            end
            if (k < 34) begin
                @(negedge clk_in);
                pmt_in1 = ~pmt_in1;
            end
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({pulse_out, count_valid, phcountbool, pmt_out} !== 5'b00000) begin
            bad++; $display("[TB] FAIL async_reset_outputs: got %b expected 00000",
                            {pulse_out, count_valid, phcountbool, pmt_out});
        end
        total++;
        if ({count0, led} !== 40'd0) begin
            bad++; $display("[TB] FAIL async_reset_counts: got %0d/%0d expected 0/0", count0, led);
        end
        pmt_in1 = 1'b0;
        @(negedge clk_in);
        reset_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_in);
            #1;
            expPulse[0] = ((k - 1) % 32) < 8;
            expPulse[1] = (((k - 1) % 32) >= 16) && (((k - 1) % 32) < 24);
            total++;
            if (pulse_out !== expPulse) begin
                bad++; $display("[TB] FAIL restart_pulse_out k=%0d: got %b expected %b", k, pulse_out, expPulse);
            end
        end
    endtask

    initial begin
        #500us;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_fast_pulses();
        test_slow_pulses();
        test_counting(4, 3, 4);
        test_counting(8, 7, 8);
        test_sync_external();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
